// File: rtl/vga_tx_pkg.sv
// rtl/vga_tx_pkg.sv - shared timing defaults, FSM encoding and FIFO entry layout for vga_stream_tx
package vga_tx_pkg;

  localparam int DEF_H_ACT = 640;
  localparam int DEF_H_FP  = 16;
  localparam int DEF_H_SW  = 96;
  localparam int DEF_H_BP  = 48;
  localparam int DEF_V_ACT = 480;
  localparam int DEF_V_FP  = 10;
  localparam int DEF_V_SW  = 2;
  localparam int DEF_V_BP  = 33;
  localparam int RGB_W     = 24;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } tx_state_t;

  typedef struct packed {
    logic             sof;
    logic [RGB_W-1:0] rgb;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/vga_tx_fifo.sv
// rtl/vga_tx_fifo.sv - show-ahead synchronous FIFO buffering {sof,rgb} pixels ahead of the timing engine
module vga_tx_fifo
  import vga_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        I_PCLK,
  input  logic        I_RST_N,
  input  logic        push,
  input  fifo_entry_t wr_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t    mem [DEPTH];
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge I_PCLK) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/vga_stream_tx.sv
// rtl/vga_stream_tx.sv - VGA timing transmitter fed by a valid/ready pixel stream with SOF alignment
// Optional VGA_TX_STATS_EN adds saturating frame and underflow counters.
module vga_stream_tx
  import vga_tx_pkg::*;
#(
  parameter int          H_ACT      = DEF_H_ACT,
  parameter int          H_FP       = DEF_H_FP,
  parameter int          H_SW       = DEF_H_SW,
  parameter int          H_BP       = DEF_H_BP,
  parameter int          V_ACT      = DEF_V_ACT,
  parameter int          V_FP       = DEF_V_FP,
  parameter int          V_SW       = DEF_V_SW,
  parameter int          V_BP       = DEF_V_BP,
  parameter logic        SYNC_POL   = 1'b1,
  parameter logic [23:0] FILL_COLOR = 24'h000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        I_PCLK,
  input  logic        I_RST_N,
  input  logic [23:0] I_PIX_DATA,
  input  logic        I_SOF,
  input  logic        I_VALID,
  output logic        O_READY,
  output logic [23:0] O_PIX_DATA,
  output logic        O_HSYNC,
  output logic        O_VSYNC,
  output logic        O_DE,
  output logic        O_LOCKED,
  output logic        O_UNDERFLOW,
  output logic        O_ALIGN_ERR
`ifdef VGA_TX_STATS_EN
  ,
  output logic [15:0] O_FRAME_CNT,
  output logic [15:0] O_UNDERFLOW_CNT
`endif
);

  localparam int HT = H_SW + H_BP + H_ACT + H_FP;
  localparam int VT = V_SW + V_BP + V_ACT + V_FP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [HW-1:0] H_SWL  = HW'(H_SW);
  localparam logic [HW-1:0] H_A0   = HW'(H_SW + H_BP);
  localparam logic [HW-1:0] H_A1   = HW'(H_SW + H_BP + H_ACT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [VW-1:0] V_SWL  = VW'(V_SW);
  localparam logic [VW-1:0] V_A0   = VW'(V_SW + V_BP);
  localparam logic [VW-1:0] V_A1   = VW'(V_SW + V_BP + V_ACT - 1);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hsync_c, vsync_c, act_c, first_c;
  logic          ready_en, full, empty, push, pop;
  fifo_entry_t   head;
  fifo_entry_t   wr_entry;
  tx_state_t     state_q, state_d;
  logic [23:0]   pix_c;
  logic          underflow_c, align_err_c;

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign hsync_c = (hcnt < H_SWL);
  assign vsync_c = (vcnt < V_SWL);
  assign act_c   = (hcnt >= H_A0) && (hcnt <= H_A1) && (vcnt >= V_A0) && (vcnt <= V_A1);
  assign first_c = act_c && (hcnt == H_A0) && (vcnt == V_A0);

  assign O_READY  = ready_en && !full;
  assign push     = I_VALID && O_READY;
  assign wr_entry = '{sof: I_SOF, rgb: I_PIX_DATA};

  vga_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .I_PCLK   (I_PCLK),
    .I_RST_N  (I_RST_N),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    pix_c       = FILL_COLOR;
    underflow_c = 1'b0;
    align_err_c = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        // Untagged pixels are flushed every cycle; a SOF head waits for the frame origin.
        if (!empty) begin
          if (!head.sof) begin
            pop = 1'b1;
          end else if (first_c) begin
            pop     = 1'b1;
            pix_c   = head.rgb;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (act_c) begin
          if (empty) begin
            underflow_c = 1'b1;
            state_d     = ST_ALIGN;
          end else if (first_c && !head.sof) begin
            pop         = 1'b1;
            align_err_c = 1'b1;
            state_d     = ST_ALIGN;
          end else if (!first_c && head.sof) begin
            align_err_c = 1'b1;
            state_d     = ST_ALIGN;
          end else begin
            pop   = 1'b1;
            pix_c = head.rgb;
          end
        end
      end
      default: state_d = ST_ALIGN;
    endcase
  end

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q     <= ST_ALIGN;
      ready_en    <= 1'b0;
      O_HSYNC     <= ~SYNC_POL;
      O_VSYNC     <= ~SYNC_POL;
      O_DE        <= 1'b0;
      O_PIX_DATA  <= '0;
      O_UNDERFLOW <= 1'b0;
      O_ALIGN_ERR <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_en    <= 1'b1;
      O_HSYNC     <= hsync_c ? SYNC_POL : ~SYNC_POL;
      O_VSYNC     <= vsync_c ? SYNC_POL : ~SYNC_POL;
      O_DE        <= act_c;
      O_PIX_DATA  <= act_c ? pix_c : '0;
      O_UNDERFLOW <= underflow_c;
      O_ALIGN_ERR <= align_err_c;
    end
  end

  assign O_LOCKED = (state_q == ST_RUN);

`ifdef VGA_TX_STATS_EN
  logic frame_wrap;
  assign frame_wrap = (hcnt == H_LAST) && (vcnt == V_LAST);

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_FRAME_CNT     <= '0;
      O_UNDERFLOW_CNT <= '0;
    end else begin
      if (frame_wrap && (O_FRAME_CNT != 16'hFFFF)) O_FRAME_CNT <= O_FRAME_CNT + 1'b1;
      if (underflow_c && (O_UNDERFLOW_CNT != 16'hFFFF)) O_UNDERFLOW_CNT <= O_UNDERFLOW_CNT + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_stream_tx.sv
// tb/tb_vga_stream_tx.sv - self-checking bench for vga_stream_tx on a reduced raster
module tb_vga_stream_tx;

  localparam int H_ACT = 8, H_FP = 2, H_SW = 3, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SW = 1, V_BP = 2;
  localparam int HT = H_SW + H_BP + H_ACT + H_FP;
  localparam int VT = V_SW + V_BP + V_ACT + V_FP;
  localparam int FPIX = H_ACT * V_ACT;
  localparam logic [23:0] FILL = 24'h123456;

  logic        I_PCLK = 1'b0;
  logic        I_RST_N;
  logic [23:0] I_PIX_DATA;
  logic        I_SOF;
  logic        I_VALID;
  logic        O_READY;
  logic [23:0] O_PIX_DATA;
  logic        O_HSYNC, O_VSYNC, O_DE, O_LOCKED, O_UNDERFLOW, O_ALIGN_ERR;
`ifdef VGA_TX_STATS_EN
  logic [15:0] O_FRAME_CNT, O_UNDERFLOW_CNT;
`endif

  vga_stream_tx #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
    .SYNC_POL(1'b1), .FILL_COLOR(FILL), .FIFO_DEPTH(4)
  ) dut (
    .I_PCLK      (I_PCLK),
    .I_RST_N     (I_RST_N),
    .I_PIX_DATA  (I_PIX_DATA),
    .I_SOF       (I_SOF),
    .I_VALID     (I_VALID),
    .O_READY     (O_READY),
    .O_PIX_DATA  (O_PIX_DATA),
    .O_HSYNC     (O_HSYNC),
    .O_VSYNC     (O_VSYNC),
    .O_DE        (O_DE),
    .O_LOCKED    (O_LOCKED),
    .O_UNDERFLOW (O_UNDERFLOW),
    .O_ALIGN_ERR (O_ALIGN_ERR)
`ifdef VGA_TX_STATS_EN
    ,
    .O_FRAME_CNT     (O_FRAME_CNT),
    .O_UNDERFLOW_CNT (O_UNDERFLOW_CNT)
`endif
  );

  always #5 I_PCLK = ~I_PCLK;

  typedef struct packed {
    logic [23:0] rgb;
    logic        locked;
    logic        uf;
    logic        err;
  } exp_t;

  // fault: 0 none, 1 underflow, 2 early SOF
  typedef struct {
    int junk;
    int len;
    bit wait_uf;
    int exp_good;
    int fault;
  } frame_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc;

  function automatic logic [23:0] pix_val(input int f, input int i);
    return {8'(8'hC0 + f), 8'h5A, 8'(i)};
  endfunction

  always @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Timing reference: outputs after edge k reflect raster position k-1.
  always @(negedge I_PCLK) begin
    if (I_RST_N) begin
      logic [2:0] exp_t3;
      int n, h, v;
      exp_t got;
      exp_t want;
      if (cyc == 0) begin
        exp_t3 = 3'b000;
      end else begin
        n = cyc - 1;
        h = n % HT;
        v = (n / HT) % VT;
        exp_t3 = {h < H_SW, v < V_SW,
                  (h >= H_SW + H_BP) && (h < H_SW + H_BP + H_ACT) &&
                  (v >= V_SW + V_BP) && (v < V_SW + V_BP + V_ACT)};
      end
      checks++;
      if ({O_HSYNC, O_VSYNC, O_DE} !== exp_t3) begin
        errors++;
        $display("FAIL timing cyc=%0d got=%b required=%b", cyc, {O_HSYNC, O_VSYNC, O_DE}, exp_t3);
      end
      if (O_DE && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = '{rgb: O_PIX_DATA, locked: O_LOCKED, uf: O_UNDERFLOW, err: O_ALIGN_ERR};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL pixel cyc=%0d got rgb=%h lk=%b uf=%b ae=%b required rgb=%h lk=%b uf=%b ae=%b",
                   cyc, got.rgb, got.locked, got.uf, got.err, want.rgb, want.locked, want.uf, want.err);
        end
      end else if (!O_DE) begin
        checks++;
        if ({O_PIX_DATA, O_UNDERFLOW, O_ALIGN_ERR} !== 26'd0) begin
          errors++;
          $display("FAIL blank_quiet cyc=%0d got pix=%h uf=%b ae=%b required 0", cyc, O_PIX_DATA, O_UNDERFLOW, O_ALIGN_ERR);
        end
      end
    end
  end

  task automatic chk_reset(input string name);
    checks++;
    if ({O_HSYNC, O_VSYNC, O_DE, O_PIX_DATA, O_LOCKED, O_UNDERFLOW, O_ALIGN_ERR, O_READY} !== 31'd0) begin
      errors++;
      $display("FAIL %s got hs=%b vs=%b de=%b pix=%h lk=%b uf=%b ae=%b rdy=%b required all 0",
               name, O_HSYNC, O_VSYNC, O_DE, O_PIX_DATA, O_LOCKED, O_UNDERFLOW, O_ALIGN_ERR, O_READY);
    end
  endtask

  task automatic chk_ready(input string name);
    checks++;
    if (O_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s got O_READY=%b required 1", name, O_READY);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [23:0] d, input logic s);
    int t = 0;
    I_PIX_DATA = d;
    I_SOF      = s;
    I_VALID    = 1'b1;
    while (!O_READY && t < 1000) begin
      @(posedge I_PCLK); #1;
      t++;
    end
    if (t >= 1000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no O_READY required handshake");
    end
    @(posedge I_PCLK); #1;
    I_VALID = 1'b0;
    I_SOF   = 1'b0;
  endtask

  frame_t frames[5];

  initial begin
    frames[0] = '{junk: 0, len: FPIX, wait_uf: 1'b0, exp_good: FPIX, fault: 0};
    frames[1] = '{junk: 0, len: 10,   wait_uf: 1'b1, exp_good: 10,   fault: 1};
    frames[2] = '{junk: 5, len: FPIX, wait_uf: 1'b0, exp_good: FPIX, fault: 0};
    frames[3] = '{junk: 0, len: 10,   wait_uf: 1'b0, exp_good: 10,   fault: 2};
    frames[4] = '{junk: 0, len: FPIX, wait_uf: 1'b0, exp_good: FPIX, fault: 0};

    I_RST_N = 1'b0; I_VALID = 1'b0; I_SOF = 1'b0; I_PIX_DATA = '0;
    repeat (3) @(posedge I_PCLK);
    #1 chk_reset("reset_hold");
    #1 I_RST_N = 1'b1;
    @(posedge I_PCLK); #1 chk_ready("ready_after_release");

    repeat (20) @(posedge I_PCLK);
    #3 I_RST_N = 1'b0;
    #1 chk_reset("reset_midline");
    repeat (2) @(posedge I_PCLK);
    #2 I_RST_N = 1'b1;
    @(posedge I_PCLK); #1 chk_ready("ready_after_rerelease");

    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < FPIX; i++) begin
        if (i < frames[f].exp_good)
          exp_q.push_back('{rgb: pix_val(f, i), locked: 1'b1, uf: 1'b0, err: 1'b0});
        else
          exp_q.push_back('{rgb: FILL, locked: 1'b0,
                            uf: (i == frames[f].exp_good) && (frames[f].fault == 1),
                            err: (i == frames[f].exp_good) && (frames[f].fault == 2)});
      end
      for (int j = 0; j < frames[f].junk; j++) send({16'hBAD0, 8'(j)}, 1'b0);
      for (int i = 0; i < frames[f].len; i++) send(pix_val(f, i), i == 0);
      if (frames[f].wait_uf) begin
        int t = 0;
        while (!O_UNDERFLOW && t < 600) begin
          @(posedge I_PCLK); #1;
          t++;
        end
        checks++;
        if (!O_UNDERFLOW) begin
          errors++;
          $display("FAIL underflow_wait got no O_UNDERFLOW pulse required one");
        end
      end
    end

    begin
      int t = 0;
      while (exp_q.size() > 0 && t < 2000) begin
        @(posedge I_PCLK);
        t++;
      end
      checks++;
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain got %0d pending pixels required 0", exp_q.size());
      end
    end
    @(negedge I_PCLK);

`ifdef VGA_TX_STATS_EN
    checks++;
    if (O_FRAME_CNT !== 16'd4) begin
      errors++;
      $display("FAIL frame_cnt got %0d required 4", O_FRAME_CNT);
    end
    checks++;
    if (O_UNDERFLOW_CNT !== 16'd1) begin
      errors++;
      $display("FAIL underflow_cnt got %0d required 1", O_UNDERFLOW_CNT);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
